instr_mem_loadable: RTL and testbench

Parametrised instruction memory for the simple-ISA core. It replaces the fixed-program ROM with a RAM that a host loads at run time through an auto-incrementing streaming port. The core fetches through a request/valid port with one-cycle read latency and a stall that holds the output. The block sits between the host/testbench program loader and the core's fetch stage.

---
 rtl/instr_mem_loadable.sv | 82 ++++++++
 tb/tb_instr_mem_loadable.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_mem_loadable.sv
// instr_mem_loadable: run-time loadable instruction RAM with streaming load port and 1-cycle fetch port
// Ports:
//   clk, reset                  clock and async active-high reset
//   load_start/base/len         begin a load session of load_len words at load_base (len 0 = DEPTH)
//   load_valid/data, load_ready one word per transfer while loading, address auto-increments with wrap
//   load_done                   one-cycle pulse after the final word is written
//   fetch_req/addr/stall        fetch request; stall freezes the fetch outputs
//   fetch_valid/instr           registered fetch result, one cycle after the request
//   fetch_err                   sticky flag for a fetch attempted while loading
module instr_mem_loadable #(
    parameter int INSTR_W = 16,
    parameter int DEPTH = 256,
    parameter int ADDR_W = $clog2(DEPTH),
    parameter logic [INSTR_W-1:0] NOP_INSTR = 'h0000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load_start,
    input  logic [ADDR_W-1:0]  load_base,
    input  logic [ADDR_W:0]    load_len,
    input  logic               load_valid,
    input  logic [INSTR_W-1:0] load_data,
    output logic               load_ready,
    output logic               load_done,
    input  logic               fetch_req,
    input  logic [ADDR_W-1:0]  fetch_addr,
    input  logic               fetch_stall,
    output logic               fetch_valid,
    output logic [INSTR_W-1:0] fetch_instr,
    output logic               fetch_err
);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] LOAD = 1'b1;
    localparam logic [ADDR_W:0] ONE = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0] FULL = (ADDR_W+1)'(DEPTH);
    logic [0:0] state;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W:0] remaining;
    logic [INSTR_W-1:0] mem [DEPTH];
    logic xfer;
    logic start;
    logic fetch_go;
    assign load_ready = state == LOAD;
    assign xfer = load_ready && load_valid;
    assign start = state == IDLE && load_start;
    assign fetch_go = fetch_req && !fetch_stall;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            wr_ptr <= '0;
            remaining <= '0;
            load_done <= 1'b0;
        end else begin
            load_done <= xfer && remaining == ONE;
            if (start) begin
                state <= LOAD;
                wr_ptr <= load_base;
                remaining <= load_len == '0 ? FULL : load_len;
            end else if (xfer) begin
                wr_ptr <= wr_ptr + 1'b1;
                remaining <= remaining - ONE;
                if (remaining == ONE) state <= IDLE;
            end
        end
    end
    // Memory has no reset so contents survive a reset that aborts a load.
    always_ff @(posedge clk) begin
        if (xfer) mem[wr_ptr] <= load_data;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_valid <= 1'b0;
            fetch_instr <= NOP_INSTR;
            fetch_err <= 1'b0;
        end else begin
            if (!fetch_stall) fetch_valid <= fetch_req;
            if (fetch_go) fetch_instr <= state == LOAD ? NOP_INSTR : mem[fetch_addr];
            if (fetch_go && state == LOAD) fetch_err <= 1'b1;
            else if (start) fetch_err <= 1'b0;
        end
    end
endmodule

// File: tb/tb_instr_mem_loadable.sv
// tb_instr_mem_loadable: scoreboard bench for instr_mem_loadable
module tb_instr_mem_loadable;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic load_start = 1'b0;
    logic [7:0] load_base = '0;
    logic [8:0] load_len = '0;
    logic load_valid = 1'b0;
    logic [15:0] load_data = '0;
    logic load_ready;
    logic load_done;
    logic fetch_req = 1'b0;
    logic [7:0] fetch_addr = '0;
    logic fetch_stall = 1'b0;
    logic fetch_valid;
    logic [15:0] fetch_instr;
    logic fetch_err;
    int checks = 0;
    int errors = 0;
    logic [15:0] model_mem [256];
    logic [15:0] ld_data [8];
    logic [15:0] sb [$];

    instr_mem_loadable dut (
        .clk(clk), .reset(reset),
        .load_start(load_start), .load_base(load_base), .load_len(load_len),
        .load_valid(load_valid), .load_data(load_data), .load_ready(load_ready), .load_done(load_done),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_stall(fetch_stall),
        .fetch_valid(fetch_valid), .fetch_instr(fetch_instr), .fetch_err(fetch_err)
    );

    always #5 clk = ~clk;

    // Advance one cycle from a negedge; a fetch issued this cycle pops the scoreboard.
    task automatic step();
        bit issued;
        logic [15:0] exp;
        issued = !reset && fetch_req && !fetch_stall;
        @(posedge clk);
        #1;
        if (issued) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL scoreboard_empty fetch_instr=%h", fetch_instr);
            end else begin
                exp = sb.pop_front();
                if (fetch_valid !== 1'b1 || fetch_instr !== exp) begin
                    errors++;
                    $display("FAIL fetch_result valid=%b instr=%h expected valid=1 instr=%h", fetch_valid, fetch_instr, exp);
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic load_words(input logic [7:0] base, input int n, input bit gap);
        int i;
        bit idle_next;
        logic [7:0] a;
        i = 0;
        idle_next = 1'b0;
        load_start = 1'b1;
        load_base = base;
        load_len = 9'(n);
        step();
        load_start = 1'b0;
        checks++;
        if (load_ready !== 1'b1) begin
            errors++;
            $display("FAIL load_ready_rise got=%b expected=1", load_ready);
        end
        while (i < n) begin
            if (gap && idle_next) begin
                load_valid = 1'b0;
                idle_next = 1'b0;
            end else begin
                a = base + 8'(i);
                load_valid = 1'b1;
                load_data = ld_data[i];
                model_mem[a] = ld_data[i];
                i++;
                idle_next = 1'b1;
            end
            step();
            if (i < n) begin
                checks++;
                if (load_ready !== 1'b1 || load_done !== 1'b0) begin
                    errors++;
                    $display("FAIL load_mid ready=%b done=%b expected ready=1 done=0", load_ready, load_done);
                end
            end
        end
        load_valid = 1'b0;
        checks++;
        if (load_done !== 1'b1 || load_ready !== 1'b0) begin
            errors++;
            $display("FAIL load_end done=%b ready=%b expected done=1 ready=0", load_done, load_ready);
        end
        step();
        checks++;
        if (load_done !== 1'b0) begin
            errors++;
            $display("FAIL load_done_pulse got=%b expected=0", load_done);
        end
    endtask

    task automatic fetch_range(input logic [7:0] base, input int n);
        logic [7:0] a;
        for (int i = 0; i < n; i++) begin
            a = base + 8'(i);
            fetch_req = 1'b1;
            fetch_addr = a;
            sb.push_back(model_mem[a]);
            step();
        end
        fetch_req = 1'b0;
        step();
        checks++;
        if (fetch_valid !== 1'b0) begin
            errors++;
            $display("FAIL fetch_idle_valid got=%b expected=0", fetch_valid);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        #1;
        checks++;
        if (fetch_valid !== 1'b0 || fetch_instr !== 16'h0000 || load_ready !== 1'b0 || fetch_err !== 1'b0 || load_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_state valid=%b instr=%h ready=%b err=%b done=%b expected 0 0000 0 0 0",
                     fetch_valid, fetch_instr, load_ready, fetch_err, load_done);
        end
        @(negedge clk);
    endtask

    task automatic test_program();
        ld_data = '{16'h300a, 16'h3100, 16'h3201, 16'h3300, 16'h4031, 16'h4012, 16'h5002, 16'h90fd};
        load_words(8'd0, 8, 1'b0);
        fetch_range(8'd0, 8);
        checks++;
        if (fetch_instr !== 16'h90fd) begin
            errors++;
            $display("FAIL fetch_instr_hold got=%h expected=90fd", fetch_instr);
        end
    endtask

    task automatic test_wrap();
        ld_data[0] = 16'haaa1;
        ld_data[1] = 16'hbbb2;
        ld_data[2] = 16'hccc3;
        ld_data[3] = 16'hddd4;
        load_words(8'd254, 4, 1'b0);
        fetch_range(8'd254, 6);
    endtask

    task automatic test_gap();
        ld_data[0] = 16'h1111;
        ld_data[1] = 16'h2222;
        ld_data[2] = 16'h3333;
        ld_data[3] = 16'h4444;
        load_words(8'd16, 4, 1'b1);
        fetch_range(8'd16, 4);
    endtask

    task automatic test_fetch_during_load();
        load_start = 1'b1;
        load_base = 8'd32;
        load_len = 9'd2;
        step();
        load_start = 1'b0;
        fetch_req = 1'b1;
        fetch_addr = 8'd3;
        sb.push_back(16'h0000);
        step();
        fetch_req = 1'b0;
        checks++;
        if (fetch_err !== 1'b1) begin
            errors++;
            $display("FAIL fetch_err_set got=%b expected=1", fetch_err);
        end
        for (int i = 0; i < 2; i++) begin
            load_valid = 1'b1;
            load_data = 16'h7001 + 16'(i);
            model_mem[32+i] = 16'h7001 + 16'(i);
            step();
        end
        load_valid = 1'b0;
        fetch_range(8'd32, 2);
        fetch_range(8'd3, 1);
        checks++;
        if (fetch_err !== 1'b1 || load_ready !== 1'b0) begin
            errors++;
            $display("FAIL fetch_err_sticky err=%b ready=%b expected err=1 ready=0", fetch_err, load_ready);
        end
    endtask

    task automatic test_stall();
        fetch_req = 1'b1;
        fetch_addr = 8'd5;
        sb.push_back(model_mem[5]);
        step();
        fetch_stall = 1'b1;
        fetch_addr = 8'd6;
        for (int i = 0; i < 3; i++) begin
            fetch_req = (i % 2) == 0;
            step();
            checks++;
            if (fetch_valid !== 1'b1 || fetch_instr !== 16'h4012) begin
                errors++;
                $display("FAIL stall_hold valid=%b instr=%h expected valid=1 instr=4012", fetch_valid, fetch_instr);
            end
        end
        fetch_stall = 1'b0;
        fetch_req = 1'b0;
        step();
        checks++;
        if (fetch_valid !== 1'b0 || fetch_instr !== 16'h4012) begin
            errors++;
            $display("FAIL stall_release valid=%b instr=%h expected valid=0 instr=4012", fetch_valid, fetch_instr);
        end
    endtask

    task automatic test_reset_midload();
        load_start = 1'b1;
        load_base = 8'd64;
        load_len = 9'd5;
        step();
        load_start = 1'b0;
        checks++;
        if (fetch_err !== 1'b0 || load_ready !== 1'b1) begin
            errors++;
            $display("FAIL start_clears_err err=%b ready=%b expected err=0 ready=1", fetch_err, load_ready);
        end
        for (int i = 0; i < 2; i++) begin
            load_valid = 1'b1;
            load_data = 16'h6001 + 16'(i);
            model_mem[64+i] = 16'h6001 + 16'(i);
            step();
        end
        load_valid = 1'b0;
        reset = 1'b1;
        #1;
        checks++;
        if (load_ready !== 1'b0 || load_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_abort ready=%b done=%b expected ready=0 done=0", load_ready, load_done);
        end
        @(negedge clk);
        reset = 1'b0;
        load_valid = 1'b1;
        load_data = 16'hdead;
        step();
        load_valid = 1'b0;
        checks++;
        if (load_ready !== 1'b0 || load_done !== 1'b0) begin
            errors++;
            $display("FAIL after_reset_idle ready=%b done=%b expected ready=0 done=0", load_ready, load_done);
        end
        fetch_range(8'd64, 2);
        fetch_range(8'd16, 1);
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_program();
        test_wrap();
        test_gap();
        test_fetch_during_load();
        test_stall();
        test_reset_midload();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover got=%0d expected=0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
